// File: rtl/ysyx_25020037_wbq_pkg.sv
// Shared write-back queue configuration: result-source and load-format encodings, default width.
package ysyx_25020037_wbq_pkg;

   localparam int unsigned XLEN_DEF = 32;

   typedef enum logic [1:0] {
      SEL_ALU = 2'd0,
      SEL_LD  = 2'd1,
      SEL_CSR = 2'd2,
      SEL_RSV = 2'd3
   } res_sel_e;

   typedef enum logic [2:0] {
      LD_LB  = 3'd0,
      LD_LH  = 3'd1,
      LD_LW  = 3'd2,
      LD_LBU = 3'd4,
      LD_LHU = 3'd5
   } ld_fmt_e;

endpackage

// File: rtl/ysyx_25020037_wbq_ld_ext.sv
// Combinational load extractor: picks byte/half at the byte offset and sign/zero-extends.
module ysyx_25020037_ld_ext
   import ysyx_25020037_wbq_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF
) (
   input  logic [XLEN-1:0] raw,
   input  logic [2:0]      fmt,
   input  logic [1:0]      off,
   output logic [XLEN-1:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = raw[{off, 3'b000} +: 8];
      // halfwords are taken from the aligned half addressed by off[1]
      half_sel = off[1] ? raw[31:16] : raw[15:0];
      case (fmt)
         LD_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         LD_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
         LD_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
         LD_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
         default: data = raw;
      endcase
   end

endmodule

// File: rtl/ysyx_25020037_wbq.sv
// Write-back queue: forms the GPR result at enqueue and holds entries in strict FIFO order.
// Optional zero-latency bypass into an empty queue: define YSYX_25020037_WBQ_BYPASS_EN.
module ysyx_25020037_wbq
   import ysyx_25020037_wbq_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEF,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned RD_W  = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       lsu_valid,
   output logic                       wbu_ready,
   input  logic                       in_gpr_we,
   input  logic [RD_W-1:0]            in_rd,
   input  logic [XLEN-1:0]            in_pc,
   input  logic [1:0]                 in_sel,
   input  logic [XLEN-1:0]            in_alu_res,
   input  logic [XLEN-1:0]            in_csr_data,
   input  logic [XLEN-1:0]            in_ld_raw,
   input  logic [2:0]                 in_ld_fmt,
   input  logic [1:0]                 in_ld_off,
   input  logic                       flush,
   input  logic                       gu_ready,
   output logic                       wbu_valid,
   output logic                       out_gpr_we,
   output logic [RD_W-1:0]            out_rd,
   output logic [XLEN-1:0]            out_data,
   output logic [XLEN-1:0]            out_pc,
   output logic [$clog2(DEPTH):0]     occupancy
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   occ_q, occ_d;

   logic [XLEN-1:0] data_mem_q [DEPTH];
   logic [XLEN-1:0] pc_mem_q   [DEPTH];
   logic [RD_W-1:0] rd_mem_q   [DEPTH];
   logic [DEPTH-1:0] we_mem_q;

   logic [XLEN-1:0] ld_data;
   logic [XLEN-1:0] res_data;
   logic            res_we;
   logic            q_empty;
   logic            q_full;
   logic            byp;
   logic            push;
   logic            pop;

   ysyx_25020037_ld_ext #(
      .XLEN (XLEN)
   ) u_ld_ext (
      .raw  (in_ld_raw),
      .fmt  (in_ld_fmt),
      .off  (in_ld_off),
      .data (ld_data)
   );

   always_comb begin
      case (in_sel)
         SEL_LD:  res_data = ld_data;
         SEL_CSR: res_data = in_csr_data;
         default: res_data = in_alu_res;
      endcase
      res_we = in_gpr_we && (in_rd != '0);
   end

   always_comb begin
      q_empty = (occ_q == '0);
      q_full  = (occ_q == FULL_CNT);
`ifdef YSYX_25020037_WBQ_BYPASS_EN
      // rst gating keeps wbu_valid low during reset even though bypass is combinational
      byp = lsu_valid && gu_ready && q_empty && !flush && !rst;
`else
      byp = 1'b0;
`endif
      wbu_ready = !q_full || gu_ready;
      wbu_valid = !q_empty || byp;
      push      = lsu_valid && wbu_ready && !byp && !flush;
      pop       = !q_empty && gu_ready;
      occupancy = occ_q;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_mem_q[wr_ptr_q] <= res_data;
         pc_mem_q[wr_ptr_q]   <= in_pc;
         rd_mem_q[wr_ptr_q]   <= in_rd;
         we_mem_q[wr_ptr_q]   <= res_we;
      end
   end

   always_comb begin
      out_gpr_we = 1'b0;
      out_rd     = '0;
      out_data   = '0;
      out_pc     = '0;
      if (byp) begin
         out_gpr_we = res_we;
         out_rd     = in_rd;
         out_data   = res_data;
         out_pc     = in_pc;
      end else if (!q_empty) begin
         out_gpr_we = we_mem_q[rd_ptr_q];
         out_rd     = rd_mem_q[rd_ptr_q];
         out_data   = data_mem_q[rd_ptr_q];
         out_pc     = pc_mem_q[rd_ptr_q];
      end
   end

endmodule

// File: tb/tb_ysyx_25020037_wbq.sv
// Directed bench for the write-back queue (DEPTH=2); honours YSYX_25020037_WBQ_BYPASS_EN.
module tb_ysyx_25020037_wbq;

   logic        clk = 1'b0;
   logic        rst;
   logic        lsu_valid;
   logic        wbu_ready;
   logic        in_gpr_we;
   logic [4:0]  in_rd;
   logic [31:0] in_pc;
   logic [1:0]  in_sel;
   logic [31:0] in_alu_res;
   logic [31:0] in_csr_data;
   logic [31:0] in_ld_raw;
   logic [2:0]  in_ld_fmt;
   logic [1:0]  in_ld_off;
   logic        flush;
   logic        gu_ready;
   logic        wbu_valid;
   logic        out_gpr_we;
   logic [4:0]  out_rd;
   logic [31:0] out_data;
   logic [31:0] out_pc;
   logic [1:0]  occupancy;

   int pass_cnt  = 0;
   int total_cnt = 0;

   ysyx_25020037_wbq #(
      .XLEN  (32),
      .DEPTH (2),
      .RD_W  (5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .lsu_valid   (lsu_valid),
      .wbu_ready   (wbu_ready),
      .in_gpr_we   (in_gpr_we),
      .in_rd       (in_rd),
      .in_pc       (in_pc),
      .in_sel      (in_sel),
      .in_alu_res  (in_alu_res),
      .in_csr_data (in_csr_data),
      .in_ld_raw   (in_ld_raw),
      .in_ld_fmt   (in_ld_fmt),
      .in_ld_off   (in_ld_off),
      .flush       (flush),
      .gu_ready    (gu_ready),
      .wbu_valid   (wbu_valid),
      .out_gpr_we  (out_gpr_we),
      .out_rd      (out_rd),
      .out_data    (out_data),
      .out_pc      (out_pc),
      .occupancy   (occupancy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic alu_entry(input logic [4:0] rd, input logic [31:0] res, input logic [31:0] pc);
      in_gpr_we  = 1'b1;
      in_rd      = rd;
      in_sel     = 2'd0;
      in_alu_res = res;
      in_pc      = pc;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      total_cnt++; if (occupancy !== 2'd0) $display("FAIL reset_occ: got %0d want 0", occupancy); else pass_cnt++;
      total_cnt++; if (wbu_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", wbu_valid); else pass_cnt++;
      rst = 1'b0;
      #1;
      total_cnt++; if (wbu_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", wbu_ready); else pass_cnt++;
      total_cnt++; if (out_data !== 32'h0) $display("FAIL reset_out_zero: got %h want 0", out_data); else pass_cnt++;
   endtask

   task automatic test_alu();
      alu_entry(5'd3, 32'h12345678, 32'h0000_1000);
      gu_ready  = 1'b1;
      lsu_valid = 1'b1;
      #1;
`ifdef YSYX_25020037_WBQ_BYPASS_EN
      total_cnt++; if (wbu_valid !== 1'b1) $display("FAIL alu_byp_valid: got %b want 1", wbu_valid); else pass_cnt++;
      total_cnt++; if (out_data !== 32'h12345678) $display("FAIL alu_byp_data: got %h want 12345678", out_data); else pass_cnt++;
      step();
      lsu_valid = 1'b0;
      #1;
      total_cnt++; if (occupancy !== 2'd0) $display("FAIL alu_byp_occ: got %0d want 0", occupancy); else pass_cnt++;
      total_cnt++; if (wbu_valid !== 1'b0) $display("FAIL alu_byp_after: got %b want 0", wbu_valid); else pass_cnt++;
`else
      total_cnt++; if (wbu_valid !== 1'b0) $display("FAIL alu_pre_valid: got %b want 0", wbu_valid); else pass_cnt++;
      step();
      lsu_valid = 1'b0;
      #1;
      total_cnt++; if (wbu_valid !== 1'b1) $display("FAIL alu_valid: got %b want 1", wbu_valid); else pass_cnt++;
      total_cnt++; if (out_data !== 32'h12345678) $display("FAIL alu_data: got %h want 12345678", out_data); else pass_cnt++;
      total_cnt++; if (out_rd !== 5'd3) $display("FAIL alu_rd: got %0d want 3", out_rd); else pass_cnt++;
      total_cnt++; if (out_gpr_we !== 1'b1) $display("FAIL alu_we: got %b want 1", out_gpr_we); else pass_cnt++;
      total_cnt++; if (out_pc !== 32'h1000) $display("FAIL alu_pc: got %h want 1000", out_pc); else pass_cnt++;
      step();
      total_cnt++; if (occupancy !== 2'd0) $display("FAIL alu_occ_after: got %0d want 0", occupancy); else pass_cnt++;
      total_cnt++; if (wbu_valid !== 1'b0) $display("FAIL alu_valid_after: got %b want 0", wbu_valid); else pass_cnt++;
`endif
      gu_ready = 1'b0;
   endtask

   task automatic test_loads();
      logic [2:0]  fmt_v [8] = '{3'd0, 3'd0, 3'd5, 3'd1, 3'd4, 3'd2, 3'd3, 3'd7};
      logic [1:0]  off_v [8] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd1, 2'd0};
      logic [31:0] exp_v [8] = '{32'h0000007F, 32'hFFFFFFFF, 32'h000080FF, 32'hFFFF80FF,
                                 32'h000000FF, 32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01};
      in_ld_raw  = 32'h80FF7F01;
      in_alu_res = 32'hDEAD0000;
      for (int i = 0; i < 8; i++) begin
         in_sel    = 2'd1;
         in_rd     = 5'd7;
         in_gpr_we = 1'b1;
         in_ld_fmt = fmt_v[i];
         in_ld_off = off_v[i];
         gu_ready  = 1'b0;
         lsu_valid = 1'b1;
         step();
         lsu_valid = 1'b0;
         in_ld_raw = 32'h0;
         #1;
         total_cnt++;
         if (out_data !== exp_v[i])
            $display("FAIL load_%0d fmt=%0d off=%0d: got %h want %h", i, fmt_v[i], off_v[i], out_data, exp_v[i]);
         else pass_cnt++;
         in_ld_raw = 32'h80FF7F01;
         gu_ready  = 1'b1;
         step();
         gu_ready  = 1'b0;
      end
   endtask

   task automatic test_sel();
      in_csr_data = 32'hCAFEBABE;
      alu_entry(5'd9, 32'h00001111, 32'h2000);
      in_sel    = 2'd2;
      lsu_valid = 1'b1;
      step();
      alu_entry(5'd9, 32'h00002222, 32'h2004);
      in_sel    = 2'd3;
      step();
      lsu_valid = 1'b0;
      total_cnt++; if (out_data !== 32'hCAFEBABE) $display("FAIL sel_csr: got %h want cafebabe", out_data); else pass_cnt++;
      gu_ready = 1'b1;
      step();
      total_cnt++; if (out_data !== 32'h00002222) $display("FAIL sel_rsv: got %h want 00002222", out_data); else pass_cnt++;
      step();
      gu_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      gu_ready  = 1'b0;
      lsu_valid = 1'b1;
      alu_entry(5'd1, 32'hA, 32'hA0);
      step();
      alu_entry(5'd2, 32'hB, 32'hB0);
      step();
      lsu_valid = 1'b0;
      #1;
      total_cnt++; if (wbu_ready !== 1'b0) $display("FAIL bp_ready: got %b want 0", wbu_ready); else pass_cnt++;
      total_cnt++; if (occupancy !== 2'd2) $display("FAIL bp_occ: got %0d want 2", occupancy); else pass_cnt++;
      step();
      total_cnt++; if (out_pc !== 32'hA0) $display("FAIL bp_hold: got %h want a0", out_pc); else pass_cnt++;
      gu_ready = 1'b1;
      #1;
      total_cnt++; if (wbu_ready !== 1'b1) $display("FAIL bp_ready_drain: got %b want 1", wbu_ready); else pass_cnt++;
      step();
      total_cnt++; if (out_pc !== 32'hB0) $display("FAIL bp_second: got %h want b0", out_pc); else pass_cnt++;
      total_cnt++; if (occupancy !== 2'd1) $display("FAIL bp_occ1: got %0d want 1", occupancy); else pass_cnt++;
      step();
      total_cnt++; if (wbu_valid !== 1'b0) $display("FAIL bp_empty: got %b want 0", wbu_valid); else pass_cnt++;
      total_cnt++; if (out_pc !== 32'h0) $display("FAIL bp_out_zero: got %h want 0", out_pc); else pass_cnt++;
      gu_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      gu_ready  = 1'b0;
      lsu_valid = 1'b1;
      alu_entry(5'd1, 32'h1, 32'h100);
      step();
      alu_entry(5'd2, 32'h2, 32'h200);
      step();
      alu_entry(5'd3, 32'h3, 32'h300);
      gu_ready = 1'b1;
      #1;
      total_cnt++; if (wbu_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", wbu_ready); else pass_cnt++;
      step();
      lsu_valid = 1'b0;
      #1;
      total_cnt++; if (occupancy !== 2'd2) $display("FAIL b2b_occ: got %0d want 2", occupancy); else pass_cnt++;
      total_cnt++; if (out_pc !== 32'h200) $display("FAIL b2b_head: got %h want 200", out_pc); else pass_cnt++;
      step();
      total_cnt++; if (out_pc !== 32'h300) $display("FAIL b2b_tail: got %h want 300", out_pc); else pass_cnt++;
      total_cnt++; if (out_data !== 32'h3) $display("FAIL b2b_tail_data: got %h want 3", out_data); else pass_cnt++;
      step();
      total_cnt++; if (occupancy !== 2'd0) $display("FAIL b2b_drained: got %0d want 0", occupancy); else pass_cnt++;
      gu_ready = 1'b0;
   endtask

   task automatic test_rd0();
      gu_ready  = 1'b0;
      lsu_valid = 1'b1;
      alu_entry(5'd0, 32'h55, 32'h400);
      step();
      lsu_valid = 1'b0;
      #1;
      total_cnt++; if (out_gpr_we !== 1'b0) $display("FAIL rd0_we: got %b want 0", out_gpr_we); else pass_cnt++;
      total_cnt++; if (wbu_valid !== 1'b1) $display("FAIL rd0_valid: got %b want 1", wbu_valid); else pass_cnt++;
      gu_ready = 1'b1;
      step();
      gu_ready = 1'b0;
   endtask

   task automatic test_flush();
      gu_ready  = 1'b0;
      lsu_valid = 1'b1;
      alu_entry(5'd1, 32'h1, 32'h500);
      step();
      alu_entry(5'd2, 32'h2, 32'h504);
      step();
      alu_entry(5'd3, 32'h3, 32'h508);
      flush = 1'b1;
      step();
      flush     = 1'b0;
      lsu_valid = 1'b0;
      #1;
      total_cnt++; if (occupancy !== 2'd0) $display("FAIL flush_full_occ: got %0d want 0", occupancy); else pass_cnt++;
      total_cnt++; if (wbu_valid !== 1'b0) $display("FAIL flush_full_valid: got %b want 0", wbu_valid); else pass_cnt++;
      lsu_valid = 1'b1;
      alu_entry(5'd4, 32'h4, 32'h600);
      step();
      alu_entry(5'd5, 32'h5, 32'h604);
      flush = 1'b1;
      #1;
      total_cnt++; if (wbu_ready !== 1'b1) $display("FAIL flush_push_ready: got %b want 1", wbu_ready); else pass_cnt++;
      step();
      flush     = 1'b0;
      lsu_valid = 1'b0;
      #1;
      total_cnt++; if (occupancy !== 2'd0) $display("FAIL flush_prio_occ: got %0d want 0", occupancy); else pass_cnt++;
      step();
      total_cnt++; if (wbu_valid !== 1'b0) $display("FAIL flush_prio_valid: got %b want 0", wbu_valid); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      gu_ready  = 1'b0;
      lsu_valid = 1'b1;
      alu_entry(5'd1, 32'h1, 32'h700);
      step();
      alu_entry(5'd2, 32'h2, 32'h704);
      step();
      lsu_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      total_cnt++; if (occupancy !== 2'd0) $display("FAIL rstmid_occ: got %0d want 0", occupancy); else pass_cnt++;
      total_cnt++; if (wbu_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", wbu_valid); else pass_cnt++;
      step();
      rst      = 1'b0;
      gu_ready = 1'b1;
      step();
      total_cnt++; if (wbu_valid !== 1'b0) $display("FAIL rstmid_no_emit: got %b want 0", wbu_valid); else pass_cnt++;
      gu_ready = 1'b0;
   endtask

`ifdef YSYX_25020037_WBQ_BYPASS_EN
   task automatic test_bypass();
      alu_entry(5'd6, 32'hBEEF0001, 32'h800);
      gu_ready  = 1'b1;
      lsu_valid = 1'b1;
      #1;
      total_cnt++; if (wbu_valid !== 1'b1) $display("FAIL byp_valid: got %b want 1", wbu_valid); else pass_cnt++;
      total_cnt++; if (out_pc !== 32'h800) $display("FAIL byp_pc: got %h want 800", out_pc); else pass_cnt++;
      step();
      lsu_valid = 1'b0;
      #1;
      total_cnt++; if (occupancy !== 2'd0) $display("FAIL byp_occ: got %0d want 0", occupancy); else pass_cnt++;
      total_cnt++; if (wbu_valid !== 1'b0) $display("FAIL byp_not_stored: got %b want 0", wbu_valid); else pass_cnt++;
      gu_ready = 1'b0;
   endtask
`endif

   initial begin
      rst         = 1'b1;
      lsu_valid   = 1'b0;
      in_gpr_we   = 1'b0;
      in_rd       = '0;
      in_pc       = '0;
      in_sel      = '0;
      in_alu_res  = '0;
      in_csr_data = '0;
      in_ld_raw   = '0;
      in_ld_fmt   = '0;
      in_ld_off   = '0;
      flush       = 1'b0;
      gu_ready    = 1'b0;
      test_reset();
      test_alu();
      test_loads();
      test_sel();
      test_backpressure();
      test_back_to_back();
      test_rd0();
      test_flush();
      test_reset_mid();
`ifdef YSYX_25020037_WBQ_BYPASS_EN
      test_bypass();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
